// File: rtl/mz_pkg.sv
// mz_pkg: shared definitions for the Mach-Zehnder pulse sequencer.
//   - state_t      : sequencer state encoding (also exported for debug)
//   - timing defaults in clk cycles (PI_2_CYC, WAIT_CYC, START_CYC)
//   - MZ_CNT_W     : default width of duration inputs and counter
//   - state_succ() : fixed order of the pulse train states
package mz_pkg;

    localparam int MZ_CNT_W  = 24;
    localparam int PI_2_CYC  = 333;
    localparam int WAIT_CYC  = 66666;
    localparam int START_CYC = 66666;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEAD = 3'd1,
        ST_P1   = 3'd2,
        ST_W1   = 3'd3,
        ST_P2   = 3'd4,
        ST_W2   = 3'd5,
        ST_P3   = 3'd6,
        ST_HOLD = 3'd7
    } state_t;

    // Successor in the train: DEAD, P1, W1, P2, W2, P3, HOLD, IDLE.
    function automatic state_t state_succ(input state_t s);
        case (s)
            ST_DEAD: return ST_P1;
            ST_P1:   return ST_W1;
            ST_W1:   return ST_P2;
            ST_P2:   return ST_W2;
            ST_W2:   return ST_P3;
            ST_P3:   return ST_HOLD;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: metastability synchronizer plus registered rising-edge detect
// for an asynchronous input pin.
// Ports:
//   i_clk   - sampling clock
//   i_rst   - asynchronous active-high reset
//   i_async - asynchronous input pin
//   o_rise  - one-cycle pulse, high in the cycle after edge k+SYNC_STAGES
//             when the pin was first sampled high at edge k
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_sync_d;
    logic [STAGES:0]   r_fill;
    logic              r_rise;

    // r_fill marks when r_sync_d holds a genuine sample of the pin. Until
    // then the zeros left by reset would make a pin held high during reset
    // look like a rising edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_fill   <= '0;
            r_rise   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[STAGES-2:0], i_async};
            r_sync_d <= r_sync[STAGES-1];
            r_fill   <= {r_fill[STAGES-1:0], 1'b1};
            r_rise   <= r_sync[STAGES-1] & ~r_sync_d & r_fill[STAGES];
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/mz_pulse_sequencer.sv
// mz_pulse_sequencer: per-trigger Mach-Zehnder pulse train generator.
// Train: dead, pi/2 pulse, interval, pi pulse (2*pi/2), interval, pi/2 pulse,
// then an optional holdoff during which new triggers are rejected.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   trig           - asynchronous trigger pin, rising edge starts a train
//   abort          - synchronous, returns to IDLE at the next edge
//   cfg_dead/pi2/interval - durations in cycles, latched on acceptance
//   rf             - registered RF gate, high during the three pulses
//   busy           - high in any state other than IDLE
//   done           - one-cycle pulse on normal completion
//   overrun        - one-cycle pulse when a trigger edge is rejected
//   o_dbg_state    - current FSM state
module mz_pulse_sequencer
    import mz_pkg::*;
#(
    parameter int CNT_W       = MZ_CNT_W,
    parameter int HOLDOFF     = WAIT_CYC,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_dead,
    input  logic [CNT_W-1:0] cfg_pi2,
    input  logic [CNT_W-1:0] cfg_interval,
    output logic             rf,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output state_t           o_dbg_state
);

    localparam logic [CNT_W:0] HOLD_LEN = (CNT_W+1)'(HOLDOFF);
    localparam logic [CNT_W:0] ONE      = (CNT_W+1)'(1);

    state_t           r_state;
    logic [CNT_W:0]   r_cnt;
    logic [CNT_W-1:0] r_dead;
    logic [CNT_W-1:0] r_pi2;
    logic [CNT_W-1:0] r_interval;
    logic             r_rf;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    logic             w_rise;
    logic             w_accept;
    logic [CNT_W-1:0] w_dead;
    logic [CNT_W-1:0] w_pi2;
    logic [CNT_W-1:0] w_interval;
    state_t           w_next_state;
    state_t           w_walk;
    logic [CNT_W:0]   w_next_cnt;
    logic             w_done_next;
    logic             w_overrun_next;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (trig),
        .o_rise  (w_rise)
    );

    // Duration of a state; the pi pulse is one bit wider so 2*pi2 never wraps.
    function automatic logic [CNT_W:0] dur_of(input state_t s,
                                              input logic [CNT_W-1:0] d,
                                              input logic [CNT_W-1:0] p,
                                              input logic [CNT_W-1:0] iv);
        case (s)
            ST_DEAD:      return {1'b0, d};
            ST_P1, ST_P3: return {1'b0, p};
            ST_W1, ST_W2: return {1'b0, iv};
            ST_P2:        return {p, 1'b0};
            ST_HOLD:      return HOLD_LEN;
            default:      return '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, counter and pulse outputs
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_done_next    = 1'b0;
        w_walk         = ST_IDLE;
        w_accept       = (r_state == ST_IDLE) && w_rise && !abort;
        w_overrun_next = w_rise && (r_state != ST_IDLE);
        // On acceptance the shadows are not loaded yet, so use the inputs.
        w_dead         = w_accept ? cfg_dead     : r_dead;
        w_pi2          = w_accept ? cfg_pi2      : r_pi2;
        w_interval     = w_accept ? cfg_interval : r_interval;

        if (abort) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
        end else if (w_accept || (r_state != ST_IDLE && r_cnt == '0)) begin
            w_walk = w_accept ? ST_DEAD : state_succ(r_state);
            // Zero-length states are skipped within this same transition.
            for (int i = 0; i < 7; i++) begin
                if (w_walk != ST_IDLE &&
                    dur_of(w_walk, w_dead, w_pi2, w_interval) == '0) begin
                    w_walk = state_succ(w_walk);
                end
            end
            w_next_state = w_walk;
            w_next_cnt   = (w_walk == ST_IDLE) ? '0 :
                           dur_of(w_walk, w_dead, w_pi2, w_interval) - ONE;
            // Leaving the pulse part of the train (not the holdoff) is completion.
            w_done_next  = (r_state != ST_HOLD) &&
                           (w_walk == ST_HOLD || w_walk == ST_IDLE);
        end else if (r_state != ST_IDLE) begin
            w_next_cnt = r_cnt - ONE;
        end
    end

    // Counter, shadow config and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dead     <= '0;
            r_pi2      <= '0;
            r_interval <= '0;
            r_rf       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_cnt <= w_next_cnt;
            if (w_accept) begin
                r_dead     <= cfg_dead;
                r_pi2      <= cfg_pi2;
                r_interval <= cfg_interval;
            end
            r_rf      <= (w_next_state == ST_P1) || (w_next_state == ST_P2) ||
                         (w_next_state == ST_P3);
            r_busy    <= (w_next_state != ST_IDLE);
            r_done    <= w_done_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign rf          = r_rf;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
module tb_mz_pulse_sequencer;
  import mz_pkg::*;

  localparam int CNT_W = 24;
  localparam int S = 2;
  localparam int WIN = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic abort = 1'b0;
  logic [CNT_W-1:0] cfg_dead = '0;
  logic [CNT_W-1:0] cfg_pi2 = '0;
  logic [CNT_W-1:0] cfg_interval = '0;
  logic rf0, busy0, done0, ovr0;
  logic rf5, busy5, done5, ovr5;
  state_t st0, st5;

  always #5 clk = ~clk;

  mz_pulse_sequencer #(.CNT_W(CNT_W), .HOLDOFF(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort),
    .cfg_dead(cfg_dead), .cfg_pi2(cfg_pi2), .cfg_interval(cfg_interval),
    .rf(rf0), .busy(busy0), .done(done0), .overrun(ovr0), .o_dbg_state(st0)
  );

  mz_pulse_sequencer #(.CNT_W(CNT_W), .HOLDOFF(5), .SYNC_STAGES(S)) dut5 (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort),
    .cfg_dead(cfg_dead), .cfg_pi2(cfg_pi2), .cfg_interval(cfg_interval),
    .rf(rf5), .busy(busy5), .done(done5), .overrun(ovr5), .o_dbg_state(st5)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: on acceptance the whole train is expanded into a queue
  // of per-cycle records {rf,busy,done}; one record is consumed per clock.
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  logic [3:0] mexp[2] = '{default: 4'b0};   // {rf,busy,done,overrun}
  logic th[$];                              // trig samples since reset

  task automatic push_n(input int id, input int n, input logic [2:0] rec);
    for (int i = 0; i < n; i++) begin
      if (id == 0) exp_q0.push_back(rec);
      else exp_q1.push_back(rec);
    end
  endtask

  task automatic build_seq(input int id, input int hold);
    int d, p, iv;
    d = int'(cfg_dead);
    p = int'(cfg_pi2);
    iv = int'(cfg_interval);
    push_n(id, d, 3'b010);
    push_n(id, p, 3'b110);
    push_n(id, iv, 3'b010);
    push_n(id, 2 * p, 3'b110);
    push_n(id, iv, 3'b010);
    push_n(id, p, 3'b110);
    if (hold > 0) begin
      push_n(id, 1, 3'b011);
      push_n(id, hold - 1, 3'b010);
    end else begin
      push_n(id, 1, 3'b001);
    end
  endtask

  task automatic model_step(input int id, input int hold, input bit rise, input bit ab);
    logic [2:0] rec;
    bit was_busy, ovr;
    was_busy = mexp[id][2];
    ovr = rise && was_busy;
    rec = 3'b000;
    if (ab) begin
      if (id == 0) exp_q0.delete();
      else exp_q1.delete();
    end else begin
      if (rise && !was_busy) build_seq(id, hold);
      if (id == 0) begin
        if (exp_q0.size() > 0) rec = exp_q0.pop_front();
      end else begin
        if (exp_q1.size() > 0) rec = exp_q1.pop_front();
      end
    end
    mexp[id] = {rec, ovr};
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit rise;
    int e;
    if (rst) begin
      th.delete();
      exp_q0.delete();
      exp_q1.delete();
      mexp[0] = 4'b0;
      mexp[1] = 4'b0;
    end else begin
      th.push_back(trig);
      e = th.size();
      // A trigger sampled high at edge k is acted on at edge k+S+1.
      rise = (e >= S + 3) ? (th[e-S-2] && !th[e-S-3]) : 1'b0;
      model_step(0, 0, rise, abort);
      model_step(1, 5, rise, abort);
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("cycle_dut0", int'({rf0, busy0, done0, ovr0}), int'(mexp[0]));
      check("cycle_dut5", int'({rf5, busy5, done5, ovr5}), int'(mexp[1]));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int dead, pi2, iv;
    int t2;        // edge offset of a second trig pulse, -1 none
    int ab;        // edge offset where abort is sampled, -1 none
    int pi2_late;  // cfg_pi2 value applied from offset 4, -1 none
    int rf0, done0, ovr0, busy0, first0;
    int rf5, done5, ovr5, busy5;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int n_rf0, n_done0, n_ovr0, n_busy0, first;
    int n_rf5, n_done5, n_ovr5, n_busy5;
    n_rf0 = 0; n_done0 = 0; n_ovr0 = 0; n_busy0 = 0; first = -1;
    n_rf5 = 0; n_done5 = 0; n_ovr5 = 0; n_busy5 = 0;
    @(negedge clk);
    cfg_dead = CNT_W'(v.dead);
    cfg_pi2 = CNT_W'(v.pi2);
    cfg_interval = CNT_W'(v.iv);
    for (int c = 0; c < WIN; c++) begin
      trig = (c < 2) || (v.t2 >= 0 && c >= v.t2 && c < v.t2 + 2);
      abort = (v.ab >= 0 && c == v.ab);
      if (v.pi2_late >= 0 && c == 4) cfg_pi2 = CNT_W'(v.pi2_late);
      @(negedge clk);
      n_rf0 += int'(rf0); n_done0 += int'(done0); n_ovr0 += int'(ovr0); n_busy0 += int'(busy0);
      n_rf5 += int'(rf5); n_done5 += int'(done5); n_ovr5 += int'(ovr5); n_busy5 += int'(busy5);
      if (rf0 && first < 0) first = c;
    end
    trig = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d_rf0", idx), n_rf0, v.rf0);
    check($sformatf("v%0d_done0", idx), n_done0, v.done0);
    check($sformatf("v%0d_ovr0", idx), n_ovr0, v.ovr0);
    check($sformatf("v%0d_busy0", idx), n_busy0, v.busy0);
    check($sformatf("v%0d_first0", idx), first, v.first0);
    check($sformatf("v%0d_rf5", idx), n_rf5, v.rf5);
    check($sformatf("v%0d_done5", idx), n_done5, v.done5);
    check($sformatf("v%0d_ovr5", idx), n_ovr5, v.ovr5);
    check($sformatf("v%0d_busy5", idx), n_busy5, v.busy5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int busy_seen;
    int got;

    // Trigger edges land at t0 = offset 3; t0+d-1 is the cycle a second
    // pulse driven at offset d is seen by the FSM.
    //          dead pi2 iv  t2  ab  late | rf0 dn0 ov0 bz0 1st | rf5 dn5 ov5 bz5
    vecs[0] = '{2, 3, 4, -1, -1, -1,   12, 1, 0, 22, 5,   12, 1, 0, 27};
    vecs[1] = '{2, 3, 4, 11, -1, -1,   12, 1, 1, 22, 5,   12, 1, 1, 27};
    vecs[2] = '{2, 3, 4, 25, -1, -1,   24, 2, 0, 44, 5,   12, 1, 1, 27};
    vecs[3] = '{2, 3, 4, 29, -1, -1,   24, 2, 0, 44, 5,   24, 2, 0, 54};
    vecs[4] = '{2, 3, 4, 20, 15, -1,   18, 1, 0, 34, 5,   18, 1, 0, 39};
    vecs[5] = '{0, 1, 0, -1, -1, 9,     4, 1, 0,  4, 3,    4, 1, 0,  9};
    vecs[6] = '{1, 0, 2, -1, -1, -1,    0, 1, 0,  5, -1,   0, 1, 0, 10};
    vecs[7] = '{0, 0, 0, -1, -1, -1,    0, 1, 0,  0, -1,   0, 1, 0,  5};
    vecs[8] = '{3, 5, 1, -1, -1, -1,   20, 1, 0, 25, 6,   20, 1, 0, 30};

    // Reset with trig held high
    trig = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rf0", int'(rf0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_rf5", int'(rf5), 0);
    check("rst_busy5", int'(busy5), 0);
    check("rst_state", int'(st0), int'(ST_IDLE));
    rst = 1'b0;
    mon_en = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      busy_seen += int'(busy0) + int'(busy5);
    end
    check("no_seq_after_rst", busy_seen, 0);
    trig = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Randomized stimulus checked by the reference model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) cfg_dead = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) cfg_pi2 = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) cfg_interval = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      abort = ($urandom_range(0, 60) == 0);
    end
    abort = 1'b0;
    trig = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset while rf is high
    cfg_dead = 2; cfg_pi2 = 3; cfg_interval = 4;
    trig = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c == 2) trig = 1'b0;
      if (rf0) got = 1;
    end
    check("wait_rf_high", got, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rf0", int'(rf0), 0);
    check("async_rst_rf5", int'(rf5), 0);
    check("async_rst_busy0", int'(busy0), 0);
    @(negedge clk);
    trig = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy0", int'(busy0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
